// File: rtl/sd_buf_pkg.sv
// Shared constants and FSM encoding for the SD sector buffer.
package sd_buf_pkg;

   localparam logic [7:0] CTRL_NOP       = 8'd0;
   localparam logic [7:0] CTRL_READ      = 8'd1;
   localparam logic [7:0] CTRL_WRITE     = 8'd2;
   localparam int         SECTOR_BYTES   = 512;
   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } buf_state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// 512x8 dual-port sector RAM: one write port per side, registered reads.
// Port B (controller side) wins when both sides write the same address.
module sd_sector_ram (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] a_addr,
   input  logic       a_we,
   input  logic [7:0] a_wdata,
   output logic [7:0] a_rdata,
   input  logic [8:0] b_addr,
   input  logic       b_we,
   input  logic [7:0] b_wdata,
   output logic [7:0] b_rdata
);

   logic [7:0] mem [0:511];

   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_wdata;
      if (b_we) mem[b_addr] <= b_wdata;
   end

   // Read registers reset to zero; the array itself is never cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rdata <= 8'h00;
         b_rdata <= 8'h00;
      end else begin
         a_rdata <= mem[a_addr];
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer sitting between a host and the SD controller's data port.
// Optional BUSY watchdog enabled by defining SD_BUF_TIMEOUT_EN.
module sd_sector_buffer
   import sd_buf_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_valid,
   input  logic        i_cmd_write,
   input  logic [31:0] i_cmd_sector,
   output logic        o_cmd_ready,
   output logic        o_done,
   output logic        o_error,
   output logic [7:0]  o_status,
   input  logic [8:0]  i_host_addr,
   input  logic        i_host_we,
   input  logic [7:0]  i_host_wdata,
   output logic [7:0]  o_host_rdata,
   output logic [7:0]  o_controlreg,
   output logic [31:0] o_sd_addr,
   output logic [7:0]  o_sd_data,
   input  logic [7:0]  i_sd_data,
   input  logic [31:0] i_sd_addr,
   input  logic        i_sd_wr_nrd,
   input  logic [7:0]  i_sd_statusreg,
   input  logic        i_sd_write_statusreg
);

   localparam logic [9:0] FULL_COUNT = 10'(SECTOR_BYTES);

   buf_state_t state, state_next;
   logic       cmd_write_q;
   logic       accept;
   logic       sd_we;
   logic       host_we_gated;
   logic       timeout_hit;
   logic [9:0] byte_cnt, byte_cnt_next;
   logic       unused_addr_bits;

   assign unused_addr_bits = &{1'b0, i_sd_addr[31:9]};

   assign sd_we         = (state == BUSY) && i_sd_wr_nrd;
   assign host_we_gated = (state == IDLE) && i_host_we;
   assign byte_cnt_next = (sd_we && byte_cnt != 10'h3FF) ? byte_cnt + 10'd1 : byte_cnt;

`ifdef SD_BUF_TIMEOUT_EN
   logic [23:0] tmo_cnt;

   assign timeout_hit = (state == BUSY) && (tmo_cnt == 24'hFFFFFF);

   // Watchdog restarts on every accepted command and only advances in BUSY.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                 tmo_cnt <= 24'd0;
      else if (accept)           tmo_cnt <= 24'd0;
      else if (state == BUSY)    tmo_cnt <= tmo_cnt + 24'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   sd_sector_ram u_ram (
      .clk     (i_clk),
      .rst     (i_rst),
      .a_addr  (i_host_addr),
      .a_we    (host_we_gated),
      .a_wdata (i_host_wdata),
      .a_rdata (o_host_rdata),
      .b_addr  (i_sd_addr[8:0]),
      .b_we    (sd_we),
      .b_wdata (i_sd_data),
      .b_rdata (o_sd_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Controlreg is non-zero only in ISSUE so the controller fires exactly once.
   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      o_controlreg = CTRL_NOP;
      o_cmd_ready  = 1'b0;
      o_done       = 1'b0;
      case (state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            o_controlreg = cmd_write_q ? CTRL_WRITE : CTRL_READ;
            state_next   = BUSY;
         end
         BUSY: begin
            if (i_sd_write_statusreg || timeout_hit) state_next = DONE;
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A card read that filled fewer than a full sector is an error even with
   // a clean status byte; the status strobe beats a coincident timeout.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sd_addr   <= 32'd0;
         cmd_write_q <= 1'b0;
         o_status    <= STATUS_OK;
         o_error     <= 1'b0;
         byte_cnt    <= 10'd0;
      end else if (accept) begin
         o_sd_addr   <= i_cmd_sector;
         cmd_write_q <= i_cmd_write;
         o_error     <= 1'b0;
         byte_cnt    <= 10'd0;
      end else if (state == BUSY) begin
         byte_cnt <= byte_cnt_next;
         if (i_sd_write_statusreg) begin
            o_status <= i_sd_statusreg;
            o_error  <= (i_sd_statusreg != STATUS_OK) ||
                        (!cmd_write_q && byte_cnt_next < FULL_COUNT);
         end else if (timeout_hit) begin
            o_status <= STATUS_TIMEOUT;
            o_error  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed self-checking bench for sd_sector_buffer; define SD_BUF_TIMEOUT_EN
// to also exercise the BUSY watchdog.
module tb_sd_sector_buffer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cmd_valid;
   logic        i_cmd_write;
   logic [31:0] i_cmd_sector;
   logic        o_cmd_ready;
   logic        o_done;
   logic        o_error;
   logic [7:0]  o_status;
   logic [8:0]  i_host_addr;
   logic        i_host_we;
   logic [7:0]  i_host_wdata;
   logic [7:0]  o_host_rdata;
   logic [7:0]  o_controlreg;
   logic [31:0] o_sd_addr;
   logic [7:0]  o_sd_data;
   logic [7:0]  i_sd_data;
   logic [31:0] i_sd_addr;
   logic        i_sd_wr_nrd;
   logic [7:0]  i_sd_statusreg;
   logic        i_sd_write_statusreg;

   int checks   = 0;
   int failures = 0;

   sd_sector_buffer dut (
      .i_clk                (i_clk),
      .i_rst                (i_rst),
      .i_cmd_valid          (i_cmd_valid),
      .i_cmd_write          (i_cmd_write),
      .i_cmd_sector         (i_cmd_sector),
      .o_cmd_ready          (o_cmd_ready),
      .o_done               (o_done),
      .o_error              (o_error),
      .o_status             (o_status),
      .i_host_addr          (i_host_addr),
      .i_host_we            (i_host_we),
      .i_host_wdata         (i_host_wdata),
      .o_host_rdata         (o_host_rdata),
      .o_controlreg         (o_controlreg),
      .o_sd_addr            (o_sd_addr),
      .o_sd_data            (o_sd_data),
      .i_sd_data            (i_sd_data),
      .i_sd_addr            (i_sd_addr),
      .i_sd_wr_nrd          (i_sd_wr_nrd),
      .i_sd_statusreg       (i_sd_statusreg),
      .i_sd_write_statusreg (i_sd_write_statusreg)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents a command for one edge; the DUT is then in ISSUE.
   task automatic applyStimulus(input logic write, input logic [31:0] sector);
      i_cmd_valid  = 1'b1;
      i_cmd_write  = write;
      i_cmd_sector = sector;
      tick();
      i_cmd_valid  = 1'b0;
   endtask

   task automatic sdFill(input int count, input logic [7:0] xor_key);
      for (int k = 0; k < count; k++) begin
         i_sd_addr   = 32'(k);
         i_sd_data   = 8'(k) ^ xor_key;
         i_sd_wr_nrd = 1'b1;
         tick();
      end
      i_sd_wr_nrd = 1'b0;
   endtask

   task automatic sdStatus(input logic [7:0] status);
      i_sd_statusreg       = status;
      i_sd_write_statusreg = 1'b1;
      tick();
      i_sd_write_statusreg = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_sector = 32'd0;
      i_host_addr = 9'd0; i_host_we = 1'b0; i_host_wdata = 8'd0;
      i_sd_data = 8'd0; i_sd_addr = 32'd0; i_sd_wr_nrd = 1'b0;
      i_sd_statusreg = 8'd0; i_sd_write_statusreg = 1'b0;
      tick(); tick();
      checkOutput("rst_ready",    32'(o_cmd_ready),  32'd1);
      checkOutput("rst_done",     32'(o_done),       32'd0);
      checkOutput("rst_error",    32'(o_error),      32'd0);
      checkOutput("rst_status",   32'(o_status),     32'h00);
      checkOutput("rst_ctrl",     32'(o_controlreg), 32'd0);
      checkOutput("rst_sd_addr",  o_sd_addr,         32'd0);
      checkOutput("rst_sd_data",  32'(o_sd_data),    32'd0);
      checkOutput("rst_host_rd",  32'(o_host_rdata), 32'd0);
      i_rst = 1'b0;

      $display("[TB] full sector read, status 0x00");
      applyStimulus(1'b0, 32'h10);
      checkOutput("rd_issue_ctrl", 32'(o_controlreg), 32'd1);
      checkOutput("rd_sd_addr",    o_sd_addr,         32'h10);
      checkOutput("rd_not_ready",  32'(o_cmd_ready),  32'd0);
      tick();
      checkOutput("rd_busy_ctrl",  32'(o_controlreg), 32'd0);
      sdFill(512, 8'h5A);
      sdStatus(8'h00);
      checkOutput("rd_done",       32'(o_done),       32'd1);
      checkOutput("rd_error",      32'(o_error),      32'd0);
      checkOutput("rd_status",     32'(o_status),     32'h00);
      tick();
      checkOutput("rd_done_pulse", 32'(o_done),       32'd0);
      checkOutput("rd_idle_ready", 32'(o_cmd_ready),  32'd1);
      i_host_addr = 9'd3;
      tick();
      checkOutput("rd_host_addr3", 32'(o_host_rdata), 32'h59);

      $display("[TB] host fill then sector write");
      for (int n = 0; n < 512; n++) begin
         i_host_addr  = 9'(n);
         i_host_wdata = 8'(n);
         i_host_we    = 1'b1;
         tick();
      end
      i_host_we = 1'b0;
      applyStimulus(1'b1, 32'd7);
      checkOutput("wr_issue_ctrl", 32'(o_controlreg), 32'd2);
      checkOutput("wr_sd_addr",    o_sd_addr,         32'd7);
      i_sd_addr = 32'd300;
      tick();
      checkOutput("wr_ctrl_once",  32'(o_controlreg), 32'd0);
      tick();
      checkOutput("wr_sd_data300", 32'(o_sd_data),    32'h2C);
      i_sd_addr = 32'hABCD_E12D;
      tick();
      checkOutput("wr_addr_wrap",  32'(o_sd_data),    32'h2D);
      sdStatus(8'h00);
      checkOutput("wr_done",       32'(o_done),       32'd1);
      checkOutput("wr_no_error",   32'(o_error),      32'd0);
      tick();

      $display("[TB] read with bad status");
      applyStimulus(1'b0, 32'h20);
      tick();
      sdFill(512, 8'h5A);
      sdStatus(8'h05);
      checkOutput("bad_status",    32'(o_status),     32'h05);
      checkOutput("bad_error",     32'(o_error),      32'd1);
      tick();
      checkOutput("bad_sticky",    32'(o_error),      32'd1);

      $display("[TB] short read");
      applyStimulus(1'b0, 32'h21);
      checkOutput("err_cleared",   32'(o_error),      32'd0);
      tick();
      sdFill(100, 8'hFF);
      sdStatus(8'h00);
      checkOutput("short_status",  32'(o_status),     32'h00);
      checkOutput("short_error",   32'(o_error),      32'd1);
      tick();

      $display("[TB] command and host write during BUSY");
      applyStimulus(1'b0, 32'h22);
      tick();
      i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_sector = 32'h99;
      i_host_we = 1'b1; i_host_addr = 9'd200; i_host_wdata = 8'hEE;
      tick(); tick(); tick();
      i_cmd_valid = 1'b0; i_host_we = 1'b0;
      checkOutput("busy_sd_addr",  o_sd_addr,         32'h22);
      checkOutput("busy_ctrl",     32'(o_controlreg), 32'd0);
      checkOutput("busy_ready",    32'(o_cmd_ready),  32'd0);
      tick();
      checkOutput("busy_host_rd",  32'(o_host_rdata), 32'h92);
      sdStatus(8'h00);
      checkOutput("busy_done",     32'(o_done),       32'd1);
      tick();
      checkOutput("busy_after_adr", o_sd_addr,        32'h22);

      $display("[TB] reset mid-transfer");
      applyStimulus(1'b0, 32'h33);
      tick();
      sdFill(10, 8'h00);
      i_rst = 1'b1;
      #1;
      checkOutput("mrst_ready",    32'(o_cmd_ready),  32'd1);
      checkOutput("mrst_sd_addr",  o_sd_addr,         32'd0);
      checkOutput("mrst_error",    32'(o_error),      32'd0);
      tick();
      i_rst = 1'b0;
      i_sd_statusreg = 8'h00;
      i_sd_write_statusreg = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checkOutput("mrst_no_done", 32'(o_done), 32'd0);
      end
      i_sd_write_statusreg = 1'b0;
      i_host_addr = 9'd150;
      tick();
      checkOutput("mrst_buf_kept", 32'(o_host_rdata), 32'hCC);

`ifdef SD_BUF_TIMEOUT_EN
      $display("[TB] BUSY watchdog");
      begin
         int waited;
         waited = 0;
         applyStimulus(1'b0, 32'h44);
         tick();
         while (!o_done && waited < 32'h0100_0010) begin
            tick();
            waited++;
         end
         checkOutput("tmo_done",   32'(o_done),   32'd1);
         checkOutput("tmo_status", 32'(o_status), 32'hFF);
         checkOutput("tmo_error",  32'(o_error),  32'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
